// File: rtl/intra_edge_upsample_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | intra_edge_upsample_ctrl_if                                              |
// | Request, selector and sample-index signals of the edge upsample control. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface intra_edge_upsample_ctrl_if #(
  parameter int DIM_BITS = 10,
  parameter int ANG_BITS = 9
);
  logic                req_valid;
  logic                req_ready;
  logic [DIM_BITS-1:0] req_w;
  logic [DIM_BITS-1:0] req_h;
  logic [ANG_BITS-1:0] req_pAngle;
  logic                req_filterType;
  logic [DIM_BITS-1:0] sel_w;
  logic [DIM_BITS-1:0] sel_h;
  logic                sel_filterType;
  logic [DIM_BITS-1:0] sel_delta;
  logic                sel_useUpsample;
  logic                up_valid;
  logic                up_ready;
  logic [DIM_BITS-1:0] up_idx;
  logic                up_dir;
  logic                up_last;
  logic                ups_above;
  logic                ups_left;
  logic                done;

  // slave is the sequencer side; master is the surrounding pipeline
  modport slave (
    input  req_valid, req_w, req_h, req_pAngle, req_filterType,
    input  sel_useUpsample, up_ready,
    output req_ready, sel_w, sel_h, sel_filterType, sel_delta,
    output up_valid, up_idx, up_dir, up_last, ups_above, ups_left, done
  );

  modport master (
    output req_valid, req_w, req_h, req_pAngle, req_filterType,
    output sel_useUpsample, up_ready,
    input  req_ready, sel_w, sel_h, sel_filterType, sel_delta,
    input  up_valid, up_idx, up_dir, up_last, ups_above, ups_left, done
  );
endinterface

`default_nettype wire

// File: rtl/intra_edge_upsample_ctrl.sv
// +--------------------------------------------------------------------------+
// | intra_edge_upsample_ctrl                                                 |
// | Per-block sequencer sharing one upsample selector between above and left |
// | edges, then streaming sample indices. Option: INTRA_UPS_CTRL_ABORT_EN.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module intra_edge_upsample_ctrl #(
  parameter int DIM_BITS = 10,
  parameter int ANG_BITS = 9,
  parameter int SEL_LAT  = 1
) (
  input  wire logic clk,
  input  wire logic rst,
`ifdef INTRA_UPS_CTRL_ABORT_EN
  input  wire logic abort,
`endif
  intra_edge_upsample_ctrl_if.slave bus
);

  localparam int CNT_W = (SEL_LAT > 0) ? $clog2(SEL_LAT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEL_A = 3'd1,
    S_SEL_L = 3'd2,
    S_RUN_A = 3'd3,
    S_RUN_L = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DIM_BITS-1:0] r_w;
  logic [DIM_BITS-1:0] r_h;
  logic [ANG_BITS-1:0] r_ang;
  logic                r_ft;
  logic [CNT_W-1:0]    r_sel_cnt;
  logic [DIM_BITS-1:0] r_idx;
  logic                r_ups_above;
  logic                r_ups_left;

  logic                w_accept;
  logic                w_use_a;
  logic                w_use_l;
  logic [DIM_BITS-1:0] w_num_a;
  logic [DIM_BITS-1:0] w_num_l;
  logic [DIM_BITS-1:0] w_num;
  logic                w_sel_last;
  logic                w_is_sel;
  logic                w_hs;
  logic                w_last;
  logic                w_abort;

`ifdef INTRA_UPS_CTRL_ABORT_EN
  assign w_abort = abort && (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept   = bus.req_valid && (r_state == S_IDLE);
  assign w_use_a    = r_ang < ANG_BITS'(180);
  assign w_use_l    = r_ang > ANG_BITS'(90);
  assign w_num_a    = r_w + ((r_ang < ANG_BITS'(90))  ? r_h : '0);
  assign w_num_l    = r_h + ((r_ang > ANG_BITS'(180)) ? r_w : '0);
  assign w_num      = (r_state == S_RUN_L) ? w_num_l : w_num_a;
  assign w_is_sel   = (r_state == S_SEL_A) || (r_state == S_SEL_L);
  assign w_sel_last = (r_sel_cnt == CNT_W'(SEL_LAT));
  assign w_hs       = bus.up_valid && bus.up_ready;
  assign w_last     = (r_idx == w_num - DIM_BITS'(1));

  assign bus.req_ready      = (r_state == S_IDLE);
  assign bus.sel_w          = r_w;
  assign bus.sel_h          = r_h;
  assign bus.sel_filterType = r_ft;
  // Modular subtraction yields the two's-complement delta directly
  assign bus.sel_delta      = DIM_BITS'(r_ang) -
                              ((r_state == S_SEL_L) ? DIM_BITS'(180) : DIM_BITS'(90));
  assign bus.up_valid       = (r_state == S_RUN_A) || (r_state == S_RUN_L);
  assign bus.up_dir         = (r_state == S_RUN_L);
  assign bus.up_idx         = r_idx;
  assign bus.up_last        = bus.up_valid && w_last;
  assign bus.ups_above      = r_ups_above;
  assign bus.ups_left       = r_ups_left;
  assign bus.done           = (r_state == S_DONE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.req_valid) w_next = S_SEL_A;
      S_SEL_A: if (w_sel_last) w_next = S_SEL_L;
      S_SEL_L: begin
        // ups_left is still being written, so look at the selector directly
        if (w_sel_last) begin
          if (r_ups_above)                        w_next = S_RUN_A;
          else if (bus.sel_useUpsample && w_use_l) w_next = S_RUN_L;
          else                                    w_next = S_DONE;
        end
      end
      S_RUN_A: if (w_hs && w_last) w_next = r_ups_left ? S_RUN_L : S_DONE;
      S_RUN_L: if (w_hs && w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_w         <= '0;
      r_h         <= '0;
      r_ang       <= '0;
      r_ft        <= 1'b0;
      r_sel_cnt   <= '0;
      r_idx       <= '0;
      r_ups_above <= 1'b0;
      r_ups_left  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_sel_cnt <= (w_is_sel && (w_next == r_state)) ? r_sel_cnt + CNT_W'(1) : '0;
      if (w_next != r_state) r_idx <= '0;
      else if (w_hs)         r_idx <= r_idx + DIM_BITS'(1);

      if (w_accept) begin
        r_w         <= bus.req_w;
        r_h         <= bus.req_h;
        r_ang       <= bus.req_pAngle;
        r_ft        <= bus.req_filterType;
        r_ups_above <= 1'b0;
        r_ups_left  <= 1'b0;
      end
      if ((r_state == S_SEL_A) && w_sel_last) r_ups_above <= bus.sel_useUpsample && w_use_a;
      if ((r_state == S_SEL_L) && w_sel_last) r_ups_left  <= bus.sel_useUpsample && w_use_l;
      if (w_abort) begin
        r_ups_above <= 1'b0;
        r_ups_left  <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_intra_edge_upsample_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_intra_edge_upsample_ctrl                                              |
// | Directed bench with a behavioural upsample selector model.               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_intra_edge_upsample_ctrl;
  localparam int SEL_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   q_idx[$];
  int   q_dir[$];
  int   q_last[$];
  int   done_cnt;
  int   done_cyc;

  always #5 clk = ~clk;

  intra_edge_upsample_ctrl_if #(.DIM_BITS(10), .ANG_BITS(9)) bus ();

  intra_edge_upsample_ctrl #(.DIM_BITS(10), .ANG_BITS(9), .SEL_LAT(SEL_LAT)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef INTRA_UPS_CTRL_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  // AV1 upsample decision: |d| in 1..39 and block size within the filter limit
  function automatic logic sel_f(input logic [9:0] d, input logic [9:0] w,
                                 input logic [9:0] h, input logic ft);
    logic signed [9:0] ds;
    int ad;
    int wh;
    ds = d;
    ad = (ds < 0) ? -int'(ds) : int'(ds);
    wh = int'(w) + int'(h);
    if (ad <= 0 || ad >= 40) return 1'b0;
    return ft ? (wh <= 8) : (wh <= 16);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) bus.sel_useUpsample <= 1'b0;
    else     bus.sel_useUpsample <= sel_f(bus.sel_delta, bus.sel_w, bus.sel_h, bus.sel_filterType);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_req(input int w, input int h, input int ang, input int ft);
    @(negedge clk);
    bus.req_valid      = 1'b1;
    bus.req_w          = 10'(w);
    bus.req_h          = 10'(h);
    bus.req_pAngle     = 9'(ang);
    bus.req_filterType = 1'(ft);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // Runs one block; cycle numbers count negedges after the accepting edge
  task automatic run_block(input int w, input int h, input int ang, input int ft,
                           input bit toggle);
    bit pv;
    bit pr;
    int pidx;
    int pdir;
    int plast;
    q_idx.delete(); q_dir.delete(); q_last.delete();
    done_cnt = 0;
    done_cyc = -1;
    pv = 0; pr = 0; pidx = 0; pdir = 0; plast = 0;
    bus.up_ready = 1'b1;
    send_req(w, h, ang, ft);
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      bus.up_ready = toggle ? ((cyc % 3) == 1) : 1'b1;
      if (pv && !pr && bus.up_valid) begin
        chk("hold_idx",  int'(bus.up_idx),  pidx);
        chk("hold_dir",  int'(bus.up_dir),  pdir);
        chk("hold_last", int'(bus.up_last), plast);
      end
      if (bus.up_valid && bus.up_ready) begin
        q_idx.push_back(int'(bus.up_idx));
        q_dir.push_back(int'(bus.up_dir));
        q_last.push_back(int'(bus.up_last));
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      pv = bus.up_valid; pr = bus.up_ready;
      pidx = int'(bus.up_idx); pdir = int'(bus.up_dir); plast = int'(bus.up_last);
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    bus.up_ready = 1'b1;
    chk("back_idle_ready", int'(bus.req_ready), 1);
  endtask

  task automatic check_stream(input string tag, input int n, input int dir);
    chk({tag, "_handshakes"}, q_idx.size(), n);
    for (int i = 0; i < q_idx.size() && i < n; i++) begin
      chk({tag, "_idx"},  q_idx[i],  i);
      chk({tag, "_dir"},  q_dir[i],  dir);
      chk({tag, "_last"}, q_last[i], (i == n - 1) ? 1 : 0);
    end
  endtask

  task automatic check_result(input string tag, input int above, input int left,
                              input int cyc);
    chk({tag, "_ups_above"}, int'(bus.ups_above), above);
    chk({tag, "_ups_left"},  int'(bus.ups_left),  left);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_done_cycle"}, done_cyc, cyc);
  endtask

  initial begin
    bool_init();
    repeat (3) @(negedge clk);
    chk("reset_req_ready", int'(bus.req_ready), 1);
    chk("reset_up_valid",  int'(bus.up_valid),  0);
    chk("reset_done",      int'(bus.done),      0);
    chk("reset_ups_above", int'(bus.ups_above), 0);
    chk("reset_ups_left",  int'(bus.ups_left),  0);
    rst = 1'b0;

    // Above edge only: d=10, w+h=8
    run_block(4, 4, 100, 0, 1'b0);
    check_result("a100", 1, 0, 9);
    check_stream("a100", 4, 0);

    // Steep angle below 90 adds h to the above edge
    run_block(4, 4, 70, 0, 1'b0);
    check_result("a70", 1, 0, 13);
    check_stream("a70", 8, 0);

    // Left edge only: d=20, w+h=12, numPxL = 8+4
    run_block(4, 8, 200, 0, 1'b0);
    check_result("l200", 0, 1, 17);
    check_stream("l200", 12, 1);

    // Same with the stricter filter: 12 > 8, nothing streamed
    run_block(4, 8, 200, 1, 1'b0);
    check_result("l200ft", 0, 0, 3 + 2 * SEL_LAT);
    check_stream("l200ft", 0, 1);

    // Zero deltas never upsample
    run_block(4, 4, 90, 0, 1'b0);
    check_result("a90", 0, 0, 3 + 2 * SEL_LAT);
    check_stream("a90", 0, 0);
    run_block(4, 4, 180, 0, 1'b0);
    check_result("a180", 0, 0, 3 + 2 * SEL_LAT);
    check_stream("a180", 0, 0);

    // Backpressure: ready high every third cycle
    run_block(4, 4, 100, 0, 1'b1);
    check_result("bp", 1, 0, 17);
    check_stream("bp", 4, 0);

    // Reset during the above stream at idx 2
    bus.up_ready = 1'b1;
    send_req(4, 4, 100, 0);
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      if (bus.up_valid && bus.up_idx == 10'd2) break;
    end
    chk("pre_rst_idx", int'(bus.up_idx), 2);
    rst = 1'b1;
    #1;
    chk("rst_req_ready", int'(bus.req_ready), 1);
    chk("rst_up_valid",  int'(bus.up_valid),  0);
    chk("rst_ups_above", int'(bus.ups_above), 0);
    chk("rst_ups_left",  int'(bus.ups_left),  0);
    @(negedge clk);
    rst = 1'b0;
    run_block(4, 4, 100, 0, 1'b0);
    check_result("post_rst", 1, 0, 9);
    check_stream("post_rst", 4, 0);

`ifdef INTRA_UPS_CTRL_ABORT_EN
    send_req(4, 4, 100, 0);
    repeat (3) @(negedge clk);
    chk("abort_pre_ups_above", int'(bus.ups_above), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_req_ready", int'(bus.req_ready), 1);
    chk("abort_ups_above", int'(bus.ups_above), 0);
    chk("abort_ups_left",  int'(bus.ups_left),  0);
    done_cnt = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (bus.done || bus.up_valid) done_cnt++;
      @(negedge clk);
    end
    chk("abort_no_done", done_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic bool_init();
    bus.req_valid      = 1'b0;
    bus.req_w          = '0;
    bus.req_h          = '0;
    bus.req_pAngle     = '0;
    bus.req_filterType = 1'b0;
    bus.up_ready       = 1'b1;
  endtask

endmodule

`default_nettype wire
